mux_cmd_engine: RTL and testbench

Byte-level command processor for the console mux. It decodes commands from the UART receiver and owns the mux control state: the per-output enable mask and the per-output input selectors. It serialises read-back responses and ACK/NAK bytes to the UART transmitter. It supports any output/input count, handles write commands atomically, and aborts a stalled payload with a timeout.

---
 rtl/mux_cmd_engine.sv | 188 ++++++++++++++++++
 tb/tb_mux_cmd_engine.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_cmd_engine.sv
// mux_cmd_engine: byte-level command processor for the console mux.
// Decodes UART command bytes, owns the committed enable mask and the
// per-output input selectors, and queues read-back / ACK / NAK bytes
// for the UART transmitter.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   rx_valid, rx_byte received byte strobe and data
//   tx_ready          transmitter can accept a byte
//   tx_start, tx_byte launch strobe and byte to transmit
//   enabled_out       committed enable mask (OUTPUT_COUNT bits)
//   selectors         committed pin map, output i at [i*SEL_W +: SEL_W]
//   busy              high whenever the FSM is not in IDLE
//   cmd_error         one-cycle pulse when a NAK is queued
//
// state      | meaning
// -----------+-----------------------------------------------------
// IDLE       | waiting for an opcode byte
// RX_PAYLOAD | collecting write payload into the shadow register
// COMMIT     | validating the shadow, committing or rejecting it
// TX_LOAD    | byte presented on tx_byte, waiting for tx_ready
// TX_WAIT    | one-cycle gap after a launch, then next byte or IDLE
module mux_cmd_engine #(
  parameter int OUTPUT_COUNT = 16,
  parameter int INPUT_COUNT = 4,
  parameter logic [OUTPUT_COUNT-1:0] RESET_MASK = '0,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int SEL_W = $clog2(INPUT_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_byte,
  input  logic                          tx_ready,
  output logic                          tx_start,
  output logic [7:0]                    tx_byte,
  output logic [OUTPUT_COUNT-1:0]       enabled_out,
  output logic [OUTPUT_COUNT*SEL_W-1:0] selectors,
  output logic                          busy,
  output logic                          cmd_error
);

  localparam int MASK_BYTES = (OUTPUT_COUNT + 7) / 8;
  localparam int MAP_W      = OUTPUT_COUNT * SEL_W;
  localparam int MAP_BYTES  = (MAP_W + 7) / 8;
  localparam int BUF_BYTES  = (MASK_BYTES > MAP_BYTES) ? MASK_BYTES : MAP_BYTES;
  localparam int BUF_W      = BUF_BYTES * 8;
  localparam int CNT_W      = $clog2(BUF_BYTES + 1);
  localparam int TO_W       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_PAYLOAD,
    S_COMMIT,
    S_TX_LOAD,
    S_TX_WAIT
  } state_t;

  state_t           state;
  logic [BUF_W-1:0] shadow;
  logic [BUF_W-1:0] resp_buf;
  logic [CNT_W-1:0] rem_cnt;
  logic [CNT_W-1:0] byte_cnt;
  logic             wr_map;
  logic [TO_W-1:0]  to_cnt;

  logic [BUF_W-1:0] mask_left;
  logic [BUF_W-1:0] map_left;
  logic             map_bad;
  logic             to_fire;
  logic [CNT_W-1:0] last_idx;

  // Responses are left-aligned so the most significant byte sits on top
  // and each launch just shifts the buffer left by one byte.
  assign mask_left = BUF_W'(enabled_out) << (8 * (BUF_BYTES - MASK_BYTES));
  assign map_left  = BUF_W'(selectors) << (8 * (BUF_BYTES - MAP_BYTES));
  assign to_fire   = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_W'(1));
  assign last_idx  = wr_map ? CNT_W'(MAP_BYTES - 1) : CNT_W'(MASK_BYTES - 1);

  always_comb begin
    map_bad = 1'b0;
    for (int i = 0; i < OUTPUT_COUNT; i++) begin
      if (32'(shadow[i*SEL_W +: SEL_W]) >= INPUT_COUNT) map_bad = 1'b1;
    end
  end

  // Gating with tx_ready keeps a launch impossible while the UART is busy.
  assign tx_start = (state == S_TX_LOAD) && tx_ready;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      shadow      <= '0;
      resp_buf    <= '0;
      rem_cnt     <= '0;
      byte_cnt    <= '0;
      wr_map      <= 1'b0;
      to_cnt      <= '0;
      tx_byte     <= 8'hFF;
      cmd_error   <= 1'b0;
      enabled_out <= RESET_MASK;
      selectors   <= '0;
    end else begin
      cmd_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            case (rx_byte)
              8'h01: begin
                resp_buf <= mask_left;
                tx_byte  <= mask_left[BUF_W-1 -: 8];
                rem_cnt  <= CNT_W'(MASK_BYTES);
                state    <= S_TX_LOAD;
              end
              8'h02: begin
                resp_buf <= map_left;
                tx_byte  <= map_left[BUF_W-1 -: 8];
                rem_cnt  <= CNT_W'(MAP_BYTES);
                state    <= S_TX_LOAD;
              end
              8'h03, 8'h04: begin
                wr_map   <= (rx_byte == 8'h04);
                byte_cnt <= '0;
                shadow   <= '0;
                to_cnt   <= TO_W'(TIMEOUT_CYCLES);
                state    <= S_RX_PAYLOAD;
              end
              default: begin
                tx_byte   <= 8'hEE;
                rem_cnt   <= CNT_W'(1);
                cmd_error <= 1'b1;
                state     <= S_TX_LOAD;
              end
            endcase
          end
        end
        S_RX_PAYLOAD: begin
          // A byte arriving on the timeout cycle wins over the timeout.
          if (rx_valid) begin
            shadow   <= (shadow << 8) | BUF_W'(rx_byte);
            byte_cnt <= byte_cnt + 1'b1;
            to_cnt   <= TO_W'(TIMEOUT_CYCLES);
            if (byte_cnt == last_idx) state <= S_COMMIT;
          end else if (to_fire) begin
            shadow    <= '0;
            tx_byte   <= 8'hEE;
            rem_cnt   <= CNT_W'(1);
            cmd_error <= 1'b1;
            state     <= S_TX_LOAD;
          end else if (TIMEOUT_CYCLES != 0) begin
            to_cnt <= to_cnt - 1'b1;
          end
        end
        S_COMMIT: begin
          if (wr_map && map_bad) begin
            tx_byte   <= 8'hEE;
            cmd_error <= 1'b1;
          end else begin
            if (wr_map) selectors <= shadow[MAP_W-1:0];
            else        enabled_out <= shadow[OUTPUT_COUNT-1:0];
            tx_byte <= 8'hAA;
          end
          shadow  <= '0;
          rem_cnt <= CNT_W'(1);
          state   <= S_TX_LOAD;
        end
        S_TX_LOAD: begin
          if (tx_ready) begin
            resp_buf <= resp_buf << 8;
            rem_cnt  <= rem_cnt - 1'b1;
            state    <= S_TX_WAIT;
          end
        end
        S_TX_WAIT: begin
          if (rem_cnt != '0) begin
            tx_byte <= resp_buf[BUF_W-1 -: 8];
            state   <= S_TX_LOAD;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_cmd_engine.sv
// Testbench for mux_cmd_engine: table of command vectors on a 4-input
// instance plus hand-written timing sequences, and a 3-input instance for
// selector range rejection and reset during a response.
module tb_mux_cmd_engine;

  localparam int T = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        rx_valid, tx_ready, tx_start, busy, cmd_error;
  logic [7:0]  rx_byte, tx_byte;
  logic [15:0] enabled_out;
  logic [31:0] selectors;

  logic        rx_valid3, tx_ready3, tx_start3, busy3, cmd_error3;
  logic [7:0]  rx_byte3, tx_byte3;
  logic [15:0] enabled_out3;
  logic [31:0] selectors3;

  mux_cmd_engine #(.OUTPUT_COUNT(16), .INPUT_COUNT(4), .RESET_MASK(16'hAA55),
                   .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_byte(tx_byte),
    .enabled_out(enabled_out), .selectors(selectors), .busy(busy),
    .cmd_error(cmd_error));

  mux_cmd_engine #(.OUTPUT_COUNT(16), .INPUT_COUNT(3), .RESET_MASK(16'hAA55),
                   .TIMEOUT_CYCLES(T)) dut3 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid3), .rx_byte(rx_byte3),
    .tx_ready(tx_ready3), .tx_start(tx_start3), .tx_byte(tx_byte3),
    .enabled_out(enabled_out3), .selectors(selectors3), .busy(busy3),
    .cmd_error(cmd_error3));

  int checks = 0;
  int errors = 0;
  int err0 = 0, err3 = 0;
  bit prev_err0 = 0, prev_err3 = 0;
  bit auto_ready = 0;
  logic [7:0] q0[$];
  logic [7:0] q3[$];

  typedef struct {
    logic [39:0] cmd;
    int          n_cmd;
    logic [31:0] rsp;
    int          n_rsp;
    logic [15:0] mask;
    logic [31:0] sel;
    int          errs;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every launch pops one expected byte.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start) begin
        chk("dut0 tx_start with tx_ready low", {31'd0, tx_ready}, 32'd1);
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut0 unexpected tx: got %h expected none", tx_byte);
        end else begin
          chk("dut0 tx_byte", {24'd0, tx_byte}, {24'd0, q0.pop_front()});
        end
      end
      if (cmd_error) begin
        err0++;
        chk("dut0 cmd_error width", {31'd0, prev_err0}, 32'd0);
      end
      prev_err0 = cmd_error;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start3) begin
        chk("dut3 tx_start with tx_ready low", {31'd0, tx_ready3}, 32'd1);
        if (q3.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut3 unexpected tx: got %h expected none", tx_byte3);
        end else begin
          chk("dut3 tx_byte", {24'd0, tx_byte3}, {24'd0, q3.pop_front()});
        end
      end
      if (cmd_error3) begin
        err3++;
        chk("dut3 cmd_error width", {31'd0, prev_err3}, 32'd0);
      end
      prev_err3 = cmd_error3;
    end
  end

  // Transmitter model: after each launch, not ready for 0..3 cycles.
  initial begin
    int unsigned k;
    forever begin
      @(negedge clk);
      if (auto_ready && tx_start) begin
        @(posedge clk);
        #1 tx_ready = 1'b0;
        k = $urandom_range(0, 3);
        repeat (k) @(posedge clk);
        #1 tx_ready = 1'b1;
      end
    end
  end

  task automatic send_byte(input bit which, input logic [7:0] b);
    @(negedge clk);
    if (which) begin rx_valid3 = 1'b1; rx_byte3 = b; end
    else       begin rx_valid  = 1'b1; rx_byte  = b; end
    @(negedge clk);
    rx_valid  = 1'b0;
    rx_valid3 = 1'b0;
  endtask

  task automatic wait_idle(input bit which, input string name);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (which ? (!busy3 && q3.size() == 0) : (!busy && q0.size() == 0)) begin
        ok = 1;
        break;
      end
    end
    chk({name, " completes"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic set_vec(input int i, input logic [39:0] c, input int nc,
                         input logic [31:0] r, input int nr,
                         input logic [15:0] m, input logic [31:0] s, input int e);
    vecs[i].cmd = c; vecs[i].n_cmd = nc; vecs[i].rsp = r; vecs[i].n_rsp = nr;
    vecs[i].mask = m; vecs[i].sel = s; vecs[i].errs = e;
  endtask

  initial begin
    int e0, e3;
    logic [39:0] c;
    logic [31:0] r;

    set_vec(0,  40'h01_00000000, 1, 32'hAA55_0000, 2, 16'hAA55, 32'h00000000, 0);
    set_vec(1,  40'h03_1234_0000, 3, 32'hAA_000000, 1, 16'h1234, 32'h00000000, 0);
    set_vec(2,  40'h01_00000000, 1, 32'h1234_0000, 2, 16'h1234, 32'h00000000, 0);
    set_vec(3,  40'h04_E4E4E4E4, 5, 32'hAA_000000, 1, 16'h1234, 32'hE4E4E4E4, 0);
    set_vec(4,  40'h02_00000000, 1, 32'hE4E4E4E4,  4, 16'h1234, 32'hE4E4E4E4, 0);
    set_vec(5,  40'h07_00000000, 1, 32'hEE_000000, 1, 16'h1234, 32'hE4E4E4E4, 1);
    set_vec(6,  40'h00_00000000, 1, 32'hEE_000000, 1, 16'h1234, 32'hE4E4E4E4, 1);
    set_vec(7,  40'h04_1B00FF80, 5, 32'hAA_000000, 1, 16'h1234, 32'h1B00FF80, 0);
    set_vec(8,  40'h02_00000000, 1, 32'h1B00FF80,  4, 16'h1234, 32'h1B00FF80, 0);
    set_vec(9,  40'h03_FF00_0000, 3, 32'hAA_000000, 1, 16'hFF00, 32'h1B00FF80, 0);
    set_vec(10, 40'h01_00000000, 1, 32'hFF00_0000, 2, 16'hFF00, 32'h1B00FF80, 0);
    set_vec(11, 40'hFF_00000000, 1, 32'hEE_000000, 1, 16'hFF00, 32'h1B00FF80, 1);

    rst_n = 1'b0;
    rx_valid = 1'b0; rx_byte = 8'h00; tx_ready = 1'b1;
    rx_valid3 = 1'b0; rx_byte3 = 8'h00; tx_ready3 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset tx_start",    {31'd0, tx_start}, 32'd0);
    chk("reset tx_byte",     {24'd0, tx_byte}, 32'h000000FF);
    chk("reset busy",        {31'd0, busy}, 32'd0);
    chk("reset cmd_error",   {31'd0, cmd_error}, 32'd0);
    chk("reset enabled_out", {16'd0, enabled_out}, 32'h0000AA55);
    chk("reset selectors",   selectors, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset busy", {31'd0, busy}, 32'd0);

    // Table-driven command vectors with a randomly stalling transmitter.
    auto_ready = 1;
    for (int v = 0; v < 12; v++) begin
      e0 = err0;
      c = vecs[v].cmd;
      r = vecs[v].rsp;
      for (int k = 0; k < vecs[v].n_rsp; k++) q0.push_back(r[31-8*k -: 8]);
      for (int k = 0; k < vecs[v].n_cmd; k++) send_byte(0, c[39-8*k -: 8]);
      wait_idle(0, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d enabled_out", v), {16'd0, enabled_out}, {16'd0, vecs[v].mask});
      chk($sformatf("vec%0d selectors", v), selectors, vecs[v].sel);
      chk($sformatf("vec%0d nak count", v), err0 - e0, vecs[v].errs);
    end
    auto_ready = 0;
    repeat (5) @(negedge clk);
    tx_ready = 1'b1;

    // Read latency: first launch in the cycle after the opcode edge.
    q0.push_back(8'hFF); q0.push_back(8'h00);
    send_byte(0, 8'h01);
    chk("read latency tx_start", {31'd0, tx_start}, 32'd1);
    chk("read latency tx_byte", {24'd0, tx_byte}, 32'h000000FF);
    @(negedge clk);
    chk("read gap tx_start", {31'd0, tx_start}, 32'd0);
    @(negedge clk);
    chk("read second tx_start", {31'd0, tx_start}, 32'd1);
    wait_idle(0, "read latency");

    // Byte arriving on the timeout cycle wins.
    auto_ready = 1;
    e0 = err0;
    q0.push_back(8'hAA);
    send_byte(0, 8'h03);
    send_byte(0, 8'h9A);
    repeat (T - 1) @(negedge clk);
    rx_valid = 1'b1; rx_byte = 8'hBC;
    @(negedge clk);
    rx_valid = 1'b0;
    wait_idle(0, "byte beats timeout");
    chk("byte beats timeout mask", {16'd0, enabled_out}, 32'h00009ABC);
    chk("byte beats timeout naks", err0 - e0, 0);

    // Payload stalls for TIMEOUT_CYCLES: NAK, no commit.
    e0 = err0;
    q0.push_back(8'hEE);
    send_byte(0, 8'h03);
    send_byte(0, 8'h12);
    repeat (T - 1) @(negedge clk);
    chk("timeout not yet cmd_error", {31'd0, cmd_error}, 32'd0);
    chk("timeout not yet busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("timeout cmd_error", {31'd0, cmd_error}, 32'd1);
    wait_idle(0, "timeout");
    chk("timeout mask kept", {16'd0, enabled_out}, 32'h00009ABC);
    chk("timeout naks", err0 - e0, 1);
    auto_ready = 0;
    repeat (5) @(negedge clk);
    tx_ready = 1'b1;

    // Commit timing, with a byte dropped while in COMMIT.
    e0 = err0;
    q0.push_back(8'hAA);
    @(negedge clk); rx_valid = 1'b1; rx_byte = 8'h03;
    @(negedge clk); rx_byte = 8'h56;
    @(negedge clk); rx_byte = 8'h78;
    @(negedge clk); rx_byte = 8'h01;
    chk("commit not yet mask", {16'd0, enabled_out}, 32'h00009ABC);
    chk("commit not yet tx_start", {31'd0, tx_start}, 32'd0);
    @(negedge clk); rx_valid = 1'b0;
    chk("commit mask", {16'd0, enabled_out}, 32'h00005678);
    chk("commit ack tx_start", {31'd0, tx_start}, 32'd1);
    wait_idle(0, "commit");
    chk("commit naks", err0 - e0, 0);

    // Bytes received during a stalled response are dropped.
    tx_ready = 1'b0;
    q0.push_back(8'h56); q0.push_back(8'h78);
    send_byte(0, 8'h01);
    send_byte(0, 8'h03);
    send_byte(0, 8'h11);
    send_byte(0, 8'h22);
    chk("stalled tx_start", {31'd0, tx_start}, 32'd0);
    chk("stalled busy", {31'd0, busy}, 32'd1);
    tx_ready = 1'b1;
    wait_idle(0, "drop during response");
    chk("drop during response mask", {16'd0, enabled_out}, 32'h00005678);

    // Three-input instance: selector value 3 is out of range.
    e3 = err3;
    q3.push_back(8'hEE);
    send_byte(1, 8'h04); send_byte(1, 8'hE4); send_byte(1, 8'h00);
    send_byte(1, 8'h00); send_byte(1, 8'h00);
    wait_idle(1, "bad map");
    chk("bad map selectors", selectors3, 32'h0);
    chk("bad map naks", err3 - e3, 1);
    q3.push_back(8'hAA);
    send_byte(1, 8'h04); send_byte(1, 8'h24); send_byte(1, 8'h00);
    send_byte(1, 8'h00); send_byte(1, 8'h00);
    wait_idle(1, "good map");
    chk("good map selectors", selectors3, 32'h24000000);
    q3.push_back(8'hAA);
    send_byte(1, 8'h03); send_byte(1, 8'h12); send_byte(1, 8'h34);
    wait_idle(1, "dut3 mask");
    chk("dut3 mask", {16'd0, enabled_out3}, 32'h00001234);

    // Reset in the middle of a response.
    q3.push_back(8'h12); q3.push_back(8'h34);
    send_byte(1, 8'h01);
    chk("pre-reset tx_start", {31'd0, tx_start3}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid-reset tx_start", {31'd0, tx_start3}, 32'd0);
    chk("mid-reset tx_byte", {24'd0, tx_byte3}, 32'h000000FF);
    chk("mid-reset busy", {31'd0, busy3}, 32'd0);
    chk("mid-reset enabled_out", {16'd0, enabled_out3}, 32'h0000AA55);
    chk("mid-reset selectors", selectors3, 32'h0);
    chk("mid-reset dut0 enabled_out", {16'd0, enabled_out}, 32'h0000AA55);
    q3.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("dut0 leftover expected bytes", q0.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got still running expected finished");
    $fatal(1, "timeout");
  end

endmodule
